// File: rtl/erm_pkg.sv
// Shared definitions for the ERM instruction prefetch path.
// Contents:
//   ERM_DATA_W / ERM_ADDR_W : default instruction word and address widths
//   pf_state_t              : prefetch fetch-FSM states
package erm_pkg;

    localparam int ERM_DATA_W = 16;
    localparam int ERM_ADDR_W = 16;

    typedef enum logic [1:0] {
        PF_IDLE    = 2'd0,  // no read outstanding
        PF_REQ     = 2'd1,  // read outstanding; its word will be queued
        PF_DISCARD = 2'd2   // read outstanding; its word belongs to a flushed stream
    } pf_state_t;

endpackage

// File: rtl/erm_sync_fifo.sv
// Synchronous circular-buffer FIFO with a registered head.
// The head word is loaded from storage one cycle after it is written, so no
// combinational path exists from i_wdata to o_head_data.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_push        : write i_wdata (must not occur while full)
//   i_wdata       : entry to write
//   i_pop         : consume head; ignored while o_head_valid=0
//   i_flush       : empty the FIFO; beats push and pop
//   o_count       : occupied entries, including one not yet visible at the head
//   o_full        : o_count == DEPTH
//   o_empty       : o_count == 0
//   o_head_valid  : o_head_data holds the oldest entry
//   o_head_data   : oldest entry
module erm_sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_head_valid,
    output logic [WIDTH-1:0] o_head_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_head_valid;
    logic [WIDTH-1:0] r_head_data;

    logic             w_pop;
    logic [PW-1:0]    w_rd_nxt;
    logic [CW-1:0]    w_remain;

    assign w_pop    = i_pop & r_head_valid;
    assign w_rd_nxt = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
    // Entries already in storage once this cycle's pop is taken; only these
    // can become the next head (a word written this cycle is not readable yet).
    assign w_remain = w_pop ? r_count - CW'(1) : r_count;

    // NOTE: storage carries no reset; entries are only read once written, so
    // resetting the array would add reset fan-out without changing behaviour.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
        end else if (i_flush) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
        end else begin
            r_rd_ptr     <= w_rd_nxt;
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            r_count      <= i_push ? w_remain + CW'(1) : w_remain;
            r_head_valid <= (w_remain != '0);
            if (w_remain != '0) begin
                r_head_data <= r_mem[w_rd_nxt];
            end
        end
    end

    assign o_count      = r_count;
    assign o_full       = (r_count == CW'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign o_head_valid = r_head_valid;
    assign o_head_data  = r_head_data;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && o_full));

endmodule

// File: rtl/erm_prefetch_unit.sv
// Instruction prefetch buffer between the memory bus and the IR/AR latches.
// Fetches sequential words ahead of decode into a DEPTH-entry queue, each
// tagged with its address. flush restarts fetching at flush_addr; bus_busy
// (execute-stage data access) blocks new requests but never withdraws one.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   mem_rd, mem_addr      : instruction read request and its address
//   mem_rdy, mem_rdata    : read completion and its data
//   bus_busy              : bus owned by execute stage this cycle
//   flush, flush_addr     : discard queue / in-flight read, restart address
//   instr_valid/data/pc   : queue head
//   instr_pop             : decode consumes head
//   count                 : occupied queue entries
module erm_prefetch_unit
    import erm_pkg::*;
#(
    parameter  int                DATA_W   = ERM_DATA_W,
    parameter  int                ADDR_W   = ERM_ADDR_W,
    parameter  int                DEPTH    = 4,
    parameter  logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int                CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rdy,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              bus_busy,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_pop,
    output logic [CW-1:0]     count
);

    pf_state_t         r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_mem_addr;

    pf_state_t         w_state_nxt;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_occ;
    logic              w_room_idle;
    logic              w_room_b2b;
    logic [ADDR_W-1:0] w_addr_inc;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [ADDR_W+DATA_W-1:0] w_head;

    assign w_pop      = instr_pop & instr_valid;
    assign w_occ      = w_pop ? count - CW'(1) : count;
    assign w_addr_inc = r_mem_addr + ADDR_W'(1);

    // The outstanding read always owns a slot. From IDLE a new read needs one
    // free slot; after a push from REQ, the pushed word and the next read
    // together need two, hence the tighter bound.
    assign w_room_idle = (w_occ < CW'(DEPTH));
    assign w_room_b2b  = (w_occ < CW'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= PF_IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_mem_addr <= w_mem_addr_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_mem_addr_nxt = r_mem_addr;
        w_push         = 1'b0;
        case (r_state)
            PF_IDLE: begin
                if (flush) begin
                    w_fetch_pc_nxt = flush_addr;
                end else if (!bus_busy && w_room_idle) begin
                    w_state_nxt    = PF_REQ;
                    w_mem_addr_nxt = r_fetch_pc;
                end
            end
            PF_REQ: begin
                if (mem_rdy) begin
                    if (flush) begin
                        w_state_nxt    = PF_IDLE;
                        w_fetch_pc_nxt = flush_addr;
                    end else begin
                        w_push         = 1'b1;
                        w_fetch_pc_nxt = w_addr_inc;
                        if (!bus_busy && w_room_b2b) begin
                            w_mem_addr_nxt = w_addr_inc;
                        end else begin
                            w_state_nxt = PF_IDLE;
                        end
                    end
                end else if (flush) begin
                    // The read cannot be withdrawn; wait it out and drop its data.
                    w_state_nxt    = PF_DISCARD;
                    w_fetch_pc_nxt = flush_addr;
                end
            end
            PF_DISCARD: begin
                if (flush) begin
                    w_fetch_pc_nxt = flush_addr;
                end
                if (mem_rdy) begin
                    w_state_nxt = PF_IDLE;
                end
            end
            default: begin
                w_state_nxt = PF_IDLE;
            end
        endcase
    end

    // Decoded from the state register so reset drops the request at once.
    assign mem_rd   = (r_state != PF_IDLE);
    assign mem_addr = r_mem_addr;

    erm_sync_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_wdata      ({r_mem_addr, mem_rdata}),
        .i_pop        (w_pop),
        .i_flush      (flush),
        .o_count      (count),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty),
        .o_head_valid (instr_valid),
        .o_head_data  (w_head)
    );

    assign instr_pc   = w_head[ADDR_W+DATA_W-1:DATA_W];
    assign instr_data = w_head[DATA_W-1:0];

    a_no_req_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_fifo_full && r_state == PF_REQ));
    a_valid_not_empty: assert property (@(posedge clk) disable iff (!rst_n)
        instr_valid |-> !w_fifo_empty);

endmodule

// File: doc/erm_prefetch_unit.md
Name: erm_prefetch_unit

Overview:
Parametrised instruction prefetch buffer for the next-generation ERM core. It sits between the memory bus and the IR/AR instruction latches. It fetches sequential instruction words ahead of decode into a DEPTH-entry queue, tagging each word with its address. The queue is flushed and restarted on jump, call or return. Data-memory accesses from the execute stage have bus priority and stall prefetch.

Parameters:
DATA_W, 16, instruction/bus data width
ADDR_W, 16, address width; fetch PC wraps modulo 2^ADDR_W
DEPTH, 4, queue entries; power of two, >=2
RESET_PC, 0, fetch address loaded on reset

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
mem_rd  out  1  instruction read request to bus
mem_addr  out  ADDR_W  instruction read address
mem_rdy  in  1  bus completes current read; mem_rdata valid this cycle
mem_rdata  in  DATA_W  read data
bus_busy  in  1  execute stage owns bus this cycle; no new request may start
flush  in  1  discard queue and in-flight read; restart at flush_addr
flush_addr  in  ADDR_W  new fetch address (jump/ret target)
instr_valid  out  1  queue head valid
instr_data  out  DATA_W  queue head word
instr_pc  out  ADDR_W  address of queue head word
instr_pop  in  1  decode consumes head; ignored when instr_valid=0
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC, queue empty, state IDLE, mem_rd=0, mem_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, count=0. Reset asserted mid-request drops the request immediately; mem_rd goes 0 asynchronously.
- FSM states: IDLE, REQ, DISCARD.
- IDLE -> REQ when flush=0, bus_busy=0 and count (after this cycle's pop) < DEPTH.
  - Entering REQ registers mem_addr=fetch_pc and asserts mem_rd from the next cycle.
  - If flush=1 in IDLE: stay IDLE; fetch_pc=flush_addr.
- REQ: mem_rd=1, mem_addr held stable until mem_rdy. A request is never withdrawn.
  - mem_rdy=1, no flush: push {mem_addr, mem_rdata}; fetch_pc=mem_addr+1 (wraps to 0).
  - After that push, stay in REQ for a back-to-back request if bus_busy=0 and space remains. Otherwise go to IDLE.
  - flush=1 with mem_rdy=0: go to DISCARD; fetch_pc=flush_addr.
  - flush=1 with mem_rdy=1: drop the data, go to IDLE, fetch_pc=flush_addr.
- DISCARD: mem_rd=1 with the old address until mem_rdy. The returned data is dropped, then go to IDLE.
  - A further flush in DISCARD updates fetch_pc only.
- Space check counts the in-flight word as occupied. The queue never overflows, and at most one read is outstanding.
- Queue: circular buffer with rd/wr pointers of $clog2(DEPTH) bits, wrapping at DEPTH. count is tracked separately so full and empty are unambiguous.
  - Push and pop in the same cycle: count unchanged. Pop on empty is ignored.
  - Push while full is impossible by construction; it is an assertion failure.
- flush priority: beats pop and push in the same cycle. The queue empties next cycle (count=0, instr_valid=0).
- Latency: the first word after reset or flush is at the head 2 cycles after the first mem_rdy sample cycle. The head outputs are registered from queue storage with no comb path from mem_rdata to instr_data.
- instr_data and instr_pc are don't-care when instr_valid=0, but are driven 0 after reset.

Decomposition:
- Shared package erm_pkg:
  - fetch state enum pf_state_t {PF_IDLE, PF_REQ, PF_DISCARD}
  - default widths ERM_DATA_W=16, ERM_ADDR_W=16
- Sub-module erm_sync_fifo (parametrised WIDTH, DEPTH; push/pop/flush/count/full/empty). It holds the {addr,data} entries.
- The FSM and fetch PC live in erm_prefetch_unit.

Test Plan:
- Reset release, RESET_PC=0x0010, mem_rdy=1 every REQ cycle, no pops -> reads at 0x0010..0x0013, then mem_rd=0 with count=4. Head instr_pc=0x0010.
- Full queue, pop every cycle, mem_rdy=1 -> sustained one word per cycle. count stays 3..4, instr_pc increments by 1 each pop with no gaps.
- flush to 0x0200 while a REQ is pending at 0x0014 (mem_rdy delayed 3 cycles) -> DISCARD. The 0x0014 data never appears, and the next request is at 0x0200.
- flush and mem_rdy in the same cycle -> data dropped, count=0 next cycle, next mem_addr=flush_addr.
- fetch_pc=0xFFFF, ADDR_W=16 -> next request address 0x0000. The head sequence is 0xFFFF then 0x0000.
- bus_busy held 5 cycles in IDLE with space -> no mem_rd during busy, request starts the cycle after bus_busy drops. rst_n pulsed low mid-REQ -> mem_rd=0 immediately and all outputs at reset values.
